// File: rtl/pipearch_common.sv
// Shared encodings for the fifobram access modes used by the DMA engines and local stores.
package pipearch_common;

    typedef enum logic [1:0] {
        FB_NONE = 2'b00,
        FB_BRAM = 2'b01,
        FB_FIFO = 2'b10,
        FB_BOTH = 2'b11
    } fifobram_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on address collision.
module sdp_ram #(
    parameter int WIDTH      = 32,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [LOG2_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**LOG2_DEPTH];

    // Read and write share one block so a colliding read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/fifobram_buffer.sv
// Dual-mode local store: random-access BRAM plus a FIFO, with a configurable-latency read path,
// occupancy flags and sticky error reporting.
module fifobram_buffer
    import pipearch_common::*;
#(
    parameter int WIDTH            = 32,
    parameter int LOG2_DEPTH       = 5,
    parameter int READ_LATENCY     = 1,
    parameter int ALMOSTFULL_SLACK = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [1:0]            wfifobram,
    input  logic                  re,
    input  logic [LOG2_DEPTH-1:0] raddr,
    input  logic [1:0]            rfifobram,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  almostfull,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  req_error
);

    localparam int                  DEPTH      = 2**LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] AF_LEVEL   = (LOG2_DEPTH+1)'(DEPTH - ALMOSTFULL_SLACK);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = (LOG2_DEPTH)'(1);

    fifobram_e rmode;
    logic bram_wr, bram_rd, push_req, pop_req, bad_req, push_ok, pop_ok, rd_accept;
    logic [LOG2_DEPTH-1:0] wptr_reg, rptr_reg;
    logic [LOG2_DEPTH:0]   count_reg, count_next;
    logic empty_reg, almostfull_reg, overflow_reg, underflow_reg, req_error_reg;
    logic sel_fifo_reg;
    logic [READ_LATENCY-1:0] valid_pipe_reg, valid_shift;
    logic [WIDTH-1:0] bram_q, fifo_q, lane_data, out_data;

    // Everything presented in a clear cycle is ignored, so clear masks every request.
    always_comb begin
        rmode      = fifobram_e'(rfifobram);
        bram_wr    = we & wfifobram[0] & ~clear;
        push_req   = we & wfifobram[1] & ~clear;
        bram_rd    = re & ~clear & (rmode == FB_BRAM);
        pop_req    = re & ~clear & (rmode == FB_FIFO);
        bad_req    = re & ~clear & ((rmode == FB_NONE) || (rmode == FB_BOTH));
        pop_ok     = pop_req & (count_reg != '0);
        // A full FIFO still accepts a push when the same cycle pops; an empty one never bypasses.
        push_ok    = push_req & ((count_reg != FULL_COUNT) | pop_ok);
        rd_accept  = bram_rd | pop_ok;
        count_next = count_reg + (LOG2_DEPTH+1)'(push_ok) - (LOG2_DEPTH+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            empty_reg      <= 1'b1;
            almostfull_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            req_error_reg  <= 1'b0;
            sel_fifo_reg   <= 1'b0;
            valid_pipe_reg <= '0;
        end else if (clear) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            empty_reg      <= 1'b1;
            almostfull_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            req_error_reg  <= 1'b0;
            sel_fifo_reg   <= 1'b0;
            valid_pipe_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            count_reg      <= count_next;
            empty_reg      <= (count_next == '0);
            almostfull_reg <= (count_next >= AF_LEVEL);
            if (push_req & ~push_ok) begin
                overflow_reg <= 1'b1;
            end
            if (pop_req & ~pop_ok) begin
                underflow_reg <= 1'b1;
            end
            if (bad_req) begin
                req_error_reg <= 1'b1;
            end
            if (rd_accept) begin
                sel_fifo_reg <= pop_ok;
            end
            valid_pipe_reg <= valid_shift;
        end
    end

    sdp_ram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_bram (
        .clk   (clk),
        .we    (bram_wr),
        .waddr (waddr),
        .wdata (wdata),
        .re    (bram_rd),
        .raddr (raddr),
        .rdata (bram_q)
    );

    sdp_ram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_fifo (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wptr_reg),
        .wdata (wdata),
        .re    (pop_ok),
        .raddr (rptr_reg),
        .rdata (fifo_q)
    );

    assign lane_data = sel_fifo_reg ? fifo_q : bram_q;

    // The RAM output register is the first latency stage; extra stages are plain delay registers.
    genvar gi;
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign valid_shift = rd_accept;
            assign out_data    = lane_data;
        end else begin : g_delay
            logic [WIDTH-1:0] dly_reg [READ_LATENCY-1];
            assign valid_shift = {valid_pipe_reg[READ_LATENCY-2:0], rd_accept};
            for (gi = 0; gi < READ_LATENCY-1; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) dly_reg[gi] <= lane_data;
                end else begin : g_next
                    always_ff @(posedge clk) dly_reg[gi] <= dly_reg[gi-1];
                end
            end
            assign out_data = dly_reg[READ_LATENCY-2];
        end
    endgenerate

    assign rvalid     = valid_pipe_reg[READ_LATENCY-1];
    assign rdata      = rvalid ? out_data : '0;
    assign almostfull = almostfull_reg;
    assign empty      = empty_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;
    assign req_error  = req_error_reg;

endmodule

// File: tb/tb_fifobram_buffer.sv
// Scoreboard bench: two buffers (read latency 1 and 3) share stimulus and are checked against
// a queue/array reference model; monitors match rvalid/rdata against expected arrival cycles.
module tb_fifobram_buffer;

    localparam int DEPTH = 32;
    localparam int SLACK = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [4:0]  waddr = '0;
    logic [4:0]  raddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  wfifobram = '0;
    logic [1:0]  rfifobram = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, af_a, af_b, empty_a, empty_b;
    logic [5:0]  count_a, count_b;
    logic        ovf_a, ovf_b, unf_a, unf_b, rerr_a, rerr_b;

    fifobram_buffer #(.WIDTH(32), .LOG2_DEPTH(5), .READ_LATENCY(LAT_A), .ALMOSTFULL_SLACK(SLACK)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata),
        .wfifobram(wfifobram), .re(re), .raddr(raddr), .rfifobram(rfifobram), .rdata(rdata_a),
        .rvalid(rvalid_a), .almostfull(af_a), .empty(empty_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a), .req_error(rerr_a)
    );

    fifobram_buffer #(.WIDTH(32), .LOG2_DEPTH(5), .READ_LATENCY(LAT_B), .ALMOSTFULL_SLACK(SLACK)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata),
        .wfifobram(wfifobram), .re(re), .raddr(raddr), .rfifobram(rfifobram), .rdata(rdata_b),
        .rvalid(rvalid_b), .almostfull(af_b), .empty(empty_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b), .req_error(rerr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_bram [DEPTH];
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_rerr = 1'b0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_state();
        int n;
        n = m_fifo.size();
        chk("count_a", 32'(count_a), 32'(n));
        chk("count_b", 32'(count_b), 32'(n));
        chk("empty_a", 32'(empty_a), 32'(n == 0));
        chk("empty_b", 32'(empty_b), 32'(n == 0));
        chk("almostfull_a", 32'(af_a), 32'(n >= DEPTH - SLACK));
        chk("almostfull_b", 32'(af_b), 32'(n >= DEPTH - SLACK));
        chk("overflow_a", 32'(ovf_a), 32'(m_ovf));
        chk("overflow_b", 32'(ovf_b), 32'(m_ovf));
        chk("underflow_a", 32'(unf_a), 32'(m_unf));
        chk("underflow_b", 32'(unf_b), 32'(m_unf));
        chk("req_error_a", 32'(rerr_a), 32'(m_rerr));
        chk("req_error_b", 32'(rerr_b), 32'(m_rerr));
    endtask

    task automatic check_reset_outputs();
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_rdata_b", rdata_b, 32'd0);
        m_fifo.delete();
        q_a.delete();
        q_b.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rerr = 1'b0;
        check_state();
    endtask

    task automatic issue(input logic [31:0] d);
        exp_t e;
        e.data = d; e.due = cyc + LAT_A; q_a.push_back(e);
        e.data = d; e.due = cyc + LAT_B; q_b.push_back(e);
    endtask

    // One cycle: check registered state, drive inputs, and advance the reference model.
    task automatic step(input logic we_i, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] wf, input logic re_i, input logic [4:0] ra,
                        input logic [1:0] rf, input logic clr);
        @(negedge clk);
        #1;
        check_state();
        we = we_i; waddr = wa; wdata = wd; wfifobram = wf;
        re = re_i; raddr = ra; rfifobram = rf; clear = clr;
        if (clr) begin
            m_fifo.delete();
            q_a.delete();
            q_b.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rerr = 1'b0;
        end else begin
            if (re_i) begin
                if (rf == 2'b01) issue(m_bram[ra]);
                else if (rf == 2'b10) begin
                    if (m_fifo.size() > 0) issue(m_fifo.pop_front());
                    else m_unf = 1'b1;
                end else m_rerr = 1'b1;
            end
            if (we_i && wf[0]) m_bram[wa] = wd;
            if (we_i && wf[1]) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(wd);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    endtask

    always @(negedge clk) begin : mon_a
        logic ev;
        ev = (q_a.size() > 0) && (q_a[0].due == cyc);
        chk("rvalid_a", 32'(rvalid_a), 32'(ev));
        if (ev) begin
            chk("rdata_a", rdata_a, q_a[0].data);
            void'(q_a.pop_front());
        end
    end

    always @(negedge clk) begin : mon_b
        logic ev;
        ev = (q_b.size() > 0) && (q_b[0].due == cyc);
        chk("rvalid_b", 32'(rvalid_b), 32'(ev));
        if (ev) begin
            chk("rdata_b", rdata_b, q_b[0].data);
            void'(q_b.pop_front());
        end
    end

    initial begin
        int pw, pr;
        logic [1:0] wf, rf;
        #12;
        check_reset_outputs();
        #10 reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) step(1, 5'(i), $urandom, 2'b01, 0, 0, 2'b00, 0);

        // Basic FIFO order
        step(1, 0, 32'h11, 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'h22, 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'h33, 2'b10, 0, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        idle(4);

        // Fill, overflow, push+pop while full, drain
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 32'(i), 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'h99, 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'hAA, 2'b10, 1, 0, 2'b10, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        idle(4);

        // Dual write, then read back from both stores
        step(1, 5, 32'hABCD, 2'b11, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 1, 5, 2'b01, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        idle(4);

        // Read-during-write to the same BRAM address
        step(1, 7, 32'h44, 2'b01, 0, 0, 2'b00, 0);
        step(1, 7, 32'h55, 2'b01, 1, 7, 2'b01, 0);
        step(0, 0, 0, 2'b00, 1, 7, 2'b01, 0);
        idle(4);

        // Rejected requests, then clear
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b11, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b00, 0);
        idle(2);
        step(1, 0, 32'h77, 2'b10, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        idle(2);

        // Clear squashes in-flight pops
        step(1, 0, 32'h101, 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'h102, 2'b10, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        step(0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        idle(5);

        // Asynchronous reset mid-stream
        step(1, 0, 32'h201, 2'b10, 0, 0, 2'b00, 0);
        step(1, 0, 32'h202, 2'b10, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        step(0, 0, 0, 2'b00, 1, 0, 2'b10, 0);
        #2;
        reset_n = 1'b0;
        we = 1'b0; re = 1'b0; clear = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic with phase-varying push/pop pressure
        for (int blk = 0; blk < 20; blk++) begin
            pw = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 30 : 55);
            pr = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 80 : 55);
            for (int i = 0; i < 200; i++) begin
                case ($urandom_range(0, 9))
                    0:       wf = 2'b01;
                    1:       wf = 2'b11;
                    2:       wf = 2'b00;
                    default: wf = 2'b10;
                endcase
                case ($urandom_range(0, 29))
                    0:       rf = 2'b11;
                    1:       rf = 2'b00;
                    2, 3, 4, 5, 6, 7: rf = 2'b01;
                    default: rf = 2'b10;
                endcase
                step(($urandom_range(0, 99) < pw), 5'($urandom), $urandom, wf,
                     ($urandom_range(0, 99) < pr), 5'($urandom), rf,
                     ($urandom_range(0, 149) == 0));
            end
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
